// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, arbiter state encoding and request bundle for the data memory path
package dmem_pkg;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;
  typedef enum logic {ARB, LOCK1} arb_state_e;
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dmem_req_t;
endpackage

// File: rtl/dmem_rd_tracker.sv
// dmem_rd_tracker: remembers which port owns the in-flight read and steers mem_q back to it
// Ports: clock/reset; rd_gnt (read granted this cycle), owner (0 = port 0, 1 = port 1);
//        mem_q (registered memory output); pX_rvalid/pX_rdata (per-port read return, zero when not owner)
module dmem_rd_tracker
  import dmem_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_gnt,
  input  logic              owner,
  input  logic [DATA_W-1:0] mem_q,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata
);
  logic rd_pend, rd_owner;
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend <= rd_gnt;
      if (rd_gnt) rd_owner <= owner;
    end
  end
  // Gated by reset so a read granted just before reset never reports back.
  always_comb begin
    p0_rvalid = rd_pend && !reset && !rd_owner;
    p1_rvalid = rd_pend && !reset && rd_owner;
    p0_rdata  = p0_rvalid ? mem_q : '0;
    p1_rdata  = p1_rvalid ? mem_q : '0;
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares data_mem between the MEM stage (port 0) and a loader/DMA master (port 1)
// Ports: clock/reset; pX_req/we/addr/wdata requests, p1_lock burst ownership request;
//        pX_gnt same-cycle grants; pX_rvalid/pX_rdata read returns one cycle after a read grant;
//        mem_* strobes, addresses and data to data_mem, mem_q read data back.
// Build option: DMEM_ARB_RR_EN selects round-robin contention; otherwise port 0 has fixed priority.
module data_mem_arbiter
  import dmem_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_lock,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_rdaddress,
  output logic [ADDR_W-1:0] mem_wraddress,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_byteena_a,
  input  logic [DATA_W-1:0] mem_q
);
  localparam int CW = $clog2(MAX_BURST + 1);
  arb_state_e state, state_n;
  logic last, last_n, win1, gnt;
  logic [CW-1:0] beat_cnt, beat_n;
  dmem_req_t sel, cur, hold;
`ifdef DMEM_ARB_RR_EN
  assign win1 = !last;
`else
  assign win1 = 1'b0;
`endif
  always_comb begin
    p0_gnt = !reset && state == ARB && p0_req && !(p1_req && win1);
    p1_gnt = !reset && p1_req && (state == LOCK1 || !p0_req || win1);
    gnt    = p0_gnt || p1_gnt;
    sel    = p1_gnt ? {p1_we, p1_addr, p1_wdata} : {p0_we, p0_addr, p0_wdata};
    cur    = gnt ? sel : hold;
  end
  assign mem_wren      = gnt && cur.we;
  assign mem_rden      = gnt && !cur.we;
  assign mem_wraddress = cur.addr;
  assign mem_rdaddress = cur.addr;
  assign mem_data      = cur.wdata;
  assign mem_byteena_a = 1'b1;
  always_comb begin
    state_n = state;
    last_n  = last;
    beat_n  = beat_cnt;
    if (state == ARB) begin
`ifdef DMEM_ARB_RR_EN
      if (gnt) last_n = p1_gnt;
`endif
      if (p1_gnt && p1_lock) begin
        state_n = LOCK1;
        beat_n  = CW'(1);
      end
    end else begin
      if (p1_gnt) beat_n = beat_cnt + CW'(1);
      // Exiting hands the next contended cycle to port 0 to bound its wait.
      if (!p1_lock || !p1_req || (p1_gnt && beat_n == CW'(MAX_BURST))) begin
        state_n = ARB;
        last_n  = 1'b1;
        beat_n  = '0;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ARB;
      last     <= 1'b1;
      beat_cnt <= '0;
      hold     <= '0;
    end else begin
      state    <= state_n;
      last     <= last_n;
      beat_cnt <= beat_n;
      hold     <= cur;
    end
  end
  dmem_rd_tracker u_trk (
    .clock     (clock),
    .reset     (reset),
    .rd_gnt    (mem_rden),
    .owner     (p1_gnt),
    .mem_q     (mem_q),
    .p0_rvalid (p0_rvalid),
    .p1_rvalid (p1_rvalid),
    .p0_rdata  (p0_rdata),
    .p1_rdata  (p1_rdata)
  );
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed self-checking bench with a behavioural data_mem
module tb_data_mem_arbiter;
  logic        clock = 0, reset;
  logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
  logic [18:0] p0_addr, p1_addr;
  logic [7:0]  p0_wdata, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [7:0]  p0_rdata, p1_rdata;
  logic        mem_rden, mem_wren, mem_byteena_a;
  logic [18:0] mem_rdaddress, mem_wraddress;
  logic [7:0]  mem_data, mem_q;
  logic [7:0]  mem [0:1023];
  int n_vec = 0, n_err = 0;
  data_mem_arbiter dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_rden(mem_rden), .mem_wren(mem_wren),
    .mem_rdaddress(mem_rdaddress), .mem_wraddress(mem_wraddress),
    .mem_data(mem_data), .mem_byteena_a(mem_byteena_a), .mem_q(mem_q)
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (mem_wren) mem[mem_wraddress[9:0]] <= mem_data;
    if (mem_rden) mem_q <= mem[mem_rdaddress[9:0]];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic idle;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_lock = 0;
  endtask
  task automatic set0(input logic we, input logic [18:0] a, input logic [7:0] d);
    p0_req = 1; p0_we = we; p0_addr = a; p0_wdata = d;
  endtask
  task automatic set1(input logic we, input logic [18:0] a, input logic [7:0] d, input logic lk);
    p1_req = 1; p1_we = we; p1_addr = a; p1_wdata = d; p1_lock = lk;
  endtask
  logic exp1, prev1;
  int k;
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem_q = 8'h00;
    idle();
    reset = 1;
    set0(0, 19'h1, 8'h0);
    set1(1, 19'h2, 8'h5, 1);
    @(negedge clock);
    chk("rst_p0_gnt", p0_gnt, 0);
    chk("rst_p1_gnt", p1_gnt, 0);
    chk("rst_rden", mem_rden, 0);
    chk("rst_wren", mem_wren, 0);
    chk("rst_byteena", mem_byteena_a, 1);
    step(); step();
    reset = 0;
    idle();
    @(negedge clock);
    chk("rst_p0_rvalid", p0_rvalid, 0);
    chk("rst_p1_rvalid", p1_rvalid, 0);
    // p0 write then read back
    set0(1, 19'h1, 8'hAB);
    @(negedge clock);
    chk("wr_p0_gnt", p0_gnt, 1);
    chk("wr_wren", mem_wren, 1);
    chk("wr_addr", mem_wraddress, 19'h1);
    chk("wr_data", mem_data, 8'hAB);
    step();
    p0_we = 0;
    @(negedge clock);
    chk("rd_p0_gnt", p0_gnt, 1);
    chk("rd_rden", mem_rden, 1);
    chk("rd_wren", mem_wren, 0);
    step();
    idle();
    @(negedge clock);
    chk("rd_p0_rvalid", p0_rvalid, 1);
    chk("rd_p0_rdata", p0_rdata, 8'hAB);
    chk("rd_p1_rvalid", p1_rvalid, 0);
    chk("rd_p1_rdata", p1_rdata, 0);
    chk("idle_rden", mem_rden, 0);
    // p0 write then p1 read of same address next cycle
    set0(1, 19'h2, 8'hCD);
    step();
    idle();
    set1(0, 19'h2, 8'h0, 0);
    @(negedge clock);
    chk("xrd_p1_gnt", p1_gnt, 1);
    step();
    idle();
    @(negedge clock);
    chk("xrd_p1_rvalid", p1_rvalid, 1);
    chk("xrd_p1_rdata", p1_rdata, 8'hCD);
    chk("xrd_p0_rvalid", p0_rvalid, 0);
    // preload: p0 writes 0x10, p1 writes 0x20 (leaves p1 as last winner)
    set0(1, 19'h10, 8'h11);
    step();
    idle();
    set1(1, 19'h20, 8'h22, 0);
    step();
    idle();
    // contention: both read every cycle
    set0(0, 19'h10, 8'h0);
    set1(0, 19'h20, 8'h0, 0);
    prev1 = 0;
    for (int i = 0; i < 6; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp1 = (i % 2) == 1;
`else
      exp1 = 0;
`endif
      @(negedge clock);
      chk("con_p0_gnt", p0_gnt, !exp1);
      chk("con_p1_gnt", p1_gnt, exp1);
      if (i > 0) begin
        chk("con_p0_rvalid", p0_rvalid, !prev1);
        chk("con_p1_rvalid", p1_rvalid, prev1);
        chk("con_rdata", prev1 ? p1_rdata : p0_rdata, prev1 ? 8'h22 : 8'h11);
      end
      prev1 = exp1;
      step();
    end
    idle();
    step();
    // locked burst of 20 writes while p0 contends
    k = 0;
    set1(1, 19'h100, 8'h00, 1);
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      chk("bst_p1_gnt", p1_gnt, 1);
      chk("bst_p0_gnt", p0_gnt, 0);
      step();
      k++;
      p1_addr = 19'h100 + 19'(k);
      p1_wdata = 8'(k);
      if (c == 0) set0(1, 19'h3, 8'h55);
    end
    @(negedge clock);
    chk("bst17_p0_gnt", p0_gnt, 1);
    chk("bst17_p1_gnt", p1_gnt, 0);
    step();
    p0_req = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk("bst_resume_p1_gnt", p1_gnt, 1);
      step();
      k++;
      p1_addr = 19'h100 + 19'(k);
      p1_wdata = 8'(k);
    end
    idle();
    step();
    set0(0, 19'h10F, 8'h0);
    step();
    set0(0, 19'h113, 8'h0);
    @(negedge clock);
    chk("bst_rd_0f", p0_rdata, 8'h0F);
    step();
    set0(0, 19'h3, 8'h0);
    @(negedge clock);
    chk("bst_rd_13", p0_rdata, 8'h13);
    step();
    idle();
    @(negedge clock);
    chk("bst_rd_p0w", p0_rdata, 8'h55);
    // lock dropped after 3 beats
    set1(1, 19'h200, 8'hA0, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("drop_p1_gnt", p1_gnt, 1);
      chk("drop_p0_gnt", p0_gnt, 0);
      step();
      set0(0, 19'h1, 8'h0);
    end
    p1_req = 0;
    p1_lock = 0;
    @(negedge clock);
    chk("drop_exit_p0_gnt", p0_gnt, 0);
    step();
    @(negedge clock);
    chk("drop_after_p0_gnt", p0_gnt, 1);
    step();
    idle();
    @(negedge clock);
    chk("drop_rdata", p0_rdata, 8'hAB);
    // reset right after a p0 read grant
    set0(0, 19'h1, 8'h0);
    @(negedge clock);
    chk("mrst_p0_gnt", p0_gnt, 1);
    step();
    reset = 1;
    set1(1, 19'h5, 8'h1, 1);
    @(negedge clock);
    chk("mrst_p0_rvalid", p0_rvalid, 0);
    chk("mrst_p0_rdata", p0_rdata, 0);
    chk("mrst_gnt", {p0_gnt, p1_gnt}, 0);
    chk("mrst_strobes", {mem_rden, mem_wren}, 0);
    step();
    reset = 0;
    idle();
    @(negedge clock);
    chk("mrst_after_rvalid", p0_rvalid, 0);
    // burst aborted by reset: arbiter is back in ARB
    set1(1, 19'h300, 8'h1, 1);
    step();
    set0(0, 19'h1, 8'h0);
    @(negedge clock);
    chk("abort_locked_p0_gnt", p0_gnt, 0);
    step();
    reset = 1;
    step();
    reset = 0;
    @(negedge clock);
    chk("abort_arb_p0_gnt", p0_gnt, 1);
    chk("abort_arb_p1_gnt", p1_gnt, 0);
    step();
    idle();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
